// File: rtl/ad7689_s_axi_regs_if.sv
// ad7689_s_axi_regs_if: AXI4-Lite bus bundle for the AD7689 register block.
interface ad7689_s_axi_regs_if #(
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] S_AXI_AWADDR;
    logic [2:0]        S_AXI_AWPROT;
    logic              S_AXI_AWVALID;
    logic              S_AXI_AWREADY;
    logic [31:0]       S_AXI_WDATA;
    logic [3:0]        S_AXI_WSTRB;
    logic              S_AXI_WVALID;
    logic              S_AXI_WREADY;
    logic [1:0]        S_AXI_BRESP;
    logic              S_AXI_BVALID;
    logic              S_AXI_BREADY;
    logic [ADDR_W-1:0] S_AXI_ARADDR;
    logic [2:0]        S_AXI_ARPROT;
    logic              S_AXI_ARVALID;
    logic              S_AXI_ARREADY;
    logic [31:0]       S_AXI_RDATA;
    logic [1:0]        S_AXI_RRESP;
    logic              S_AXI_RVALID;
    logic              S_AXI_RREADY;
    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
               S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
               S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
               S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
               S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface

// File: rtl/ad7689_s_axi_regs.sv
// ad7689_s_axi_regs: AXI4-Lite slave with four RW registers and four read-only input words.
// Define AD7689_SLVERR_EN to answer writes to the read-only words with SLVERR.
module ad7689_s_axi_regs #(
    parameter int          C_S_AXI_ADDR_WIDTH = 5,
    parameter logic [31:0] C_REG_RESET        = 32'h0000_0000
) (
    input  logic                      S_AXI_ACLK,
    input  logic                      S_AXI_ARESET,
    ad7689_s_axi_regs_if.slave        s_axi,
    output logic [127:0]              reg_out,
    input  logic [127:0]              ro_in
);
`ifdef AD7689_SLVERR_EN
    localparam logic SLVERR = 1'b1;
`else
    localparam logic SLVERR = 1'b0;
`endif
    logic [3:0][31:0] regs_q, regs_d, ro_w;
    logic [2:0]       aw_idx_q, aw_idx_d, ar_idx;
    logic [31:0]      wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic [1:0]       bresp_q, bresp_d;
    logic             up_q, aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic             bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic             aw_rdy, w_rdy, ar_rdy, aw_take, w_take, ar_take, commit;
    logic             unused_ok;
    assign ro_w      = ro_in;
    assign ar_idx    = s_axi.S_AXI_ARADDR[4:2];
    assign unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, s_axi.S_AXI_AWADDR, s_axi.S_AXI_ARADDR};
    // up_q keeps every ready low until the first edge after reset releases
    assign aw_rdy = up_q & ~aw_held_q & ~bvalid_q;
    assign w_rdy  = up_q & ~w_held_q & ~bvalid_q;
    assign ar_rdy = up_q & ~rvalid_q;
    assign s_axi.S_AXI_AWREADY = aw_rdy;
    assign s_axi.S_AXI_WREADY  = w_rdy;
    assign s_axi.S_AXI_ARREADY = ar_rdy;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_BRESP   = bresp_q;
    assign s_axi.S_AXI_RVALID  = rvalid_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = 2'b00;
    assign reg_out = regs_q;
    always_comb begin
        aw_take   = s_axi.S_AXI_AWVALID & aw_rdy;
        w_take    = s_axi.S_AXI_WVALID & w_rdy;
        ar_take   = s_axi.S_AXI_ARVALID & ar_rdy;
        commit    = aw_held_q & w_held_q & ~bvalid_q;
        aw_held_d = aw_take | (aw_held_q & ~commit);
        w_held_d  = w_take | (w_held_q & ~commit);
        aw_idx_d  = aw_take ? s_axi.S_AXI_AWADDR[4:2] : aw_idx_q;
        wdata_d   = w_take ? s_axi.S_AXI_WDATA : wdata_q;
        wstrb_d   = w_take ? s_axi.S_AXI_WSTRB : wstrb_q;
        bvalid_d  = commit | (bvalid_q & ~s_axi.S_AXI_BREADY);
        bresp_d   = commit ? {SLVERR & aw_idx_q[2], 1'b0} : bresp_q;
        rvalid_d  = ar_take | (rvalid_q & ~s_axi.S_AXI_RREADY);
        rdata_d   = ar_take ? (ar_idx[2] ? ro_w[ar_idx[1:0]] : regs_q[ar_idx[1:0]]) : rdata_q;
        regs_d    = regs_q;
        for (int i = 0; i < 4; i++)
            for (int b = 0; b < 4; b++)
                if (commit && !aw_idx_q[2] && aw_idx_q[1:0] == 2'(i) && wstrb_q[b])
                    regs_d[i][8*b +: 8] = wdata_q[8*b +: 8];
    end
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            up_q      <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_idx_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            regs_q    <= {4{C_REG_RESET}};
        end else begin
            up_q      <= 1'b1;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            aw_idx_q  <= aw_idx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            regs_q    <= regs_d;
        end
    end
endmodule

// File: tb/tb_ad7689_s_axi_regs.sv
// tb_ad7689_s_axi_regs: randomized self-checking bench for ad7689_s_axi_regs.
// Expected values come from a word/byte-mask model of the register map.
`timescale 1ns/1ps
module tb_ad7689_s_axi_regs;
    localparam logic [31:0] RST = 32'h5A5A_C3C3;
`ifdef AD7689_SLVERR_EN
    localparam logic [1:0] RO_RESP = 2'b10;
`else
    localparam logic [1:0] RO_RESP = 2'b00;
`endif
    logic         clk = 1'b0, rst = 1'b1;
    logic [127:0] reg_out, ro_in;
    logic [31:0]  model [0:7];
    int           n_cmp = 0, n_bad = 0;

    ad7689_s_axi_regs_if #(.ADDR_W(5)) bus ();
    ad7689_s_axi_regs #(.C_S_AXI_ADDR_WIDTH(5), .C_REG_RESET(RST)) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst), .s_axi(bus), .reg_out(reg_out), .ro_in(ro_in));

    always #5 clk = ~clk;

    function automatic logic [31:0] merged(input logic [31:0] old, input logic [31:0] d, input logic [3:0] st);
        logic [31:0] m = {{8{st[3]}}, {8{st[2]}}, {8{st[1]}}, {8{st[0]}}};
        return (old & ~m) | (d & m);
    endfunction

    function automatic logic [1:0] exp_bresp(input logic [4:0] a);
        return (a >= 5'h10) ? RO_RESP : 2'b00;
    endfunction

    task automatic model_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] st);
        if (a < 5'h10) model[a[4:2]] = merged(model[a[4:2]], d, st);
    endtask

    task automatic set_ro(input int i, input logic [31:0] v);
        ro_in[32*i +: 32] = v;
        model[4+i] = v;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] st,
                            input int w_lead, output logic [1:0] resp, output int lat);
        bit aw_done = 0, w_done = 0, aw_go, w_go;
        int n = 0;
        resp = 2'bxx;
        lat = -1;
        @(negedge clk);
        bus.S_AXI_AWADDR = a;
        bus.S_AXI_AWPROT = 3'($urandom);
        bus.S_AXI_WDATA = d;
        bus.S_AXI_WSTRB = st;
        bus.S_AXI_WVALID = 1'b1;
        bus.S_AXI_AWVALID = (w_lead == 0);
        while (!(aw_done && w_done) && n < 50) begin
            aw_go = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
            w_go = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
            @(negedge clk);
            n++;
            if (aw_go) begin bus.S_AXI_AWVALID = 1'b0; aw_done = 1; end
            if (w_go) begin bus.S_AXI_WVALID = 1'b0; w_done = 1; end
            if (n == w_lead) bus.S_AXI_AWVALID = 1'b1;
        end
        lat = 0;
        bus.S_AXI_BREADY = 1'b1;
        while (!bus.S_AXI_BVALID && lat < 50) begin @(negedge clk); lat++; end
        n_cmp++;
        if (!bus.S_AXI_BVALID) begin
            n_bad++;
            $display("FAIL write_timeout addr=%h got BVALID=0 want 1", a);
            bus.S_AXI_AWVALID = 1'b0;
            bus.S_AXI_WVALID = 1'b0;
        end
        resp = bus.S_AXI_BRESP;
        @(negedge clk);
        bus.S_AXI_BREADY = 1'b0;
    endtask

    task automatic do_read(input logic [4:0] a, output logic [31:0] data, output logic [1:0] resp);
        int n = 0;
        @(negedge clk);
        bus.S_AXI_ARADDR = a;
        bus.S_AXI_ARPROT = 3'($urandom);
        bus.S_AXI_ARVALID = 1'b1;
        while (!bus.S_AXI_ARREADY && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        bus.S_AXI_ARVALID = 1'b0;
        while (!bus.S_AXI_RVALID && n < 100) begin @(negedge clk); n++; end
        n_cmp++;
        if (!bus.S_AXI_RVALID) begin
            n_bad++;
            $display("FAIL read_timeout addr=%h got RVALID=0 want 1", a);
        end
        data = bus.S_AXI_RDATA;
        resp = bus.S_AXI_RRESP;
        bus.S_AXI_RREADY = 1'b1;
        @(negedge clk);
        bus.S_AXI_RREADY = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY, bus.S_AXI_BVALID, bus.S_AXI_RVALID} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_flags got %b want 00000", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY,
                     bus.S_AXI_ARREADY, bus.S_AXI_BVALID, bus.S_AXI_RVALID});
        end
        n_cmp++;
        if ({bus.S_AXI_BRESP, bus.S_AXI_RRESP, bus.S_AXI_RDATA} !== 36'h0) begin
            n_bad++;
            $display("FAIL reset_resp_data got %h want 0", {bus.S_AXI_BRESP, bus.S_AXI_RRESP, bus.S_AXI_RDATA});
        end
        n_cmp++;
        if (reg_out !== {4{RST}}) begin n_bad++; $display("FAIL reset_reg_out got %h want %h", reg_out, {4{RST}}); end
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY} !== 3'b000) begin
            n_bad++;
            $display("FAIL ready_before_edge got %b want 000", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY});
        end
        @(negedge clk);
        n_cmp++;
        if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY} !== 3'b111) begin
            n_bad++;
            $display("FAIL ready_after_edge got %b want 111", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY});
        end
    endtask

    task automatic test_directed();
        logic [4:0]  addr [4] = '{5'h00, 5'h04, 5'h08, 5'h0C};
        logic [31:0] data [4] = '{32'h0101FFFF, 32'hABCD0001, 32'hDEAD0011, 32'hBEEF0011};
        logic [31:0] rd;
        logic [1:0]  r;
        int          lat;
        for (int i = 0; i < 4; i++) begin
            do_write(addr[i], data[i], 4'hF, 0, r, lat);
            model_write(addr[i], data[i], 4'hF);
            n_cmp++;
            if (r !== 2'b00) begin n_bad++; $display("FAIL dir_bresp[%0d] got %b want 00", i, r); end
        end
        for (int i = 0; i < 4; i++) begin
            do_read(addr[i], rd, r);
            n_cmp++;
            if (rd !== data[i] || r !== 2'b00) begin
                n_bad++;
                $display("FAIL dir_read[%0d] got %h/%b want %h/00", i, rd, r, data[i]);
            end
        end
        n_cmp++;
        if (reg_out !== {data[3], data[2], data[1], data[0]}) begin
            n_bad++;
            $display("FAIL dir_reg_out got %h want %h", reg_out, {data[3], data[2], data[1], data[0]});
        end
    endtask

    task automatic test_w_first();
        logic [31:0] rd;
        logic [1:0]  r;
        int          lat;
        do_write(5'h04, 32'h12345678, 4'hF, 3, r, lat);
        model_write(5'h04, 32'h12345678, 4'hF);
        n_cmp++;
        if (lat !== 1 || r !== 2'b00) begin n_bad++; $display("FAIL w_first_latency got %0d/%b want 1/00", lat, r); end
        do_read(5'h04, rd, r);
        n_cmp++;
        if (rd !== 32'h12345678) begin n_bad++; $display("FAIL w_first_read got %h want 12345678", rd); end
    endtask

    task automatic test_strobe();
        logic [1:0] r;
        int         lat;
        do_write(5'h00, 32'hFFFFFFFF, 4'hF, 0, r, lat);
        do_write(5'h00, 32'h00000000, 4'b0101, 0, r, lat);
        n_cmp++;
        if (reg_out[31:0] !== 32'hFF00FF00) begin n_bad++; $display("FAIL strobe_0101 got %h want ff00ff00", reg_out[31:0]); end
        do_write(5'h00, 32'h12345678, 4'b0000, 1, r, lat);
        model[0] = 32'hFF00FF00;
        n_cmp++;
        if (reg_out[31:0] !== 32'hFF00FF00 || r !== 2'b00) begin
            n_bad++;
            $display("FAIL strobe_0000 got %h/%b want ff00ff00/00", reg_out[31:0], r);
        end
    endtask

    task automatic test_ro();
        logic [31:0] rd;
        logic [1:0]  r;
        int          lat;
        set_ro(1, 32'h0000ABCD);
        do_read(5'h14, rd, r);
        n_cmp++;
        if (rd !== 32'h0000ABCD || r !== 2'b00) begin n_bad++; $display("FAIL ro_read got %h/%b want 0000abcd/00", rd, r); end
        do_write(5'h14, 32'hFFFF1234, 4'hF, 0, r, lat);
        n_cmp++;
        if (r !== RO_RESP) begin n_bad++; $display("FAIL ro_bresp got %b want %b", r, RO_RESP); end
        do_read(5'h14, rd, r);
        n_cmp++;
        if (rd !== 32'h0000ABCD || reg_out !== {model[3], model[2], model[1], model[0]}) begin
            n_bad++;
            $display("FAIL ro_unchanged got %h want 0000abcd", rd);
        end
    endtask

    task automatic test_stall();
        logic [31:0] rd;
        logic [1:0]  r, er;
        @(negedge clk);
        bus.S_AXI_AWADDR = 5'h08; bus.S_AXI_WDATA = 32'h600DF00D; bus.S_AXI_WSTRB = 4'hF;
        bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
        @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        model_write(5'h08, 32'h600DF00D, 4'hF);
        @(negedge clk);
        er = bus.S_AXI_BRESP;
        bus.S_AXI_AWADDR = 5'h0C; bus.S_AXI_WDATA = 32'hBADBAD00;
        bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY} !== 3'b100 || bus.S_AXI_BRESP !== 2'b00 || er !== 2'b00) begin
                n_bad++;
                $display("FAIL b_stall[%0d] got bv/awr/wr=%b bresp=%b want 100/00", i,
                         {bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, bus.S_AXI_BRESP);
            end
            @(negedge clk);
        end
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_BREADY = 1'b1;
        @(negedge clk);
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_ARADDR = 5'h08; bus.S_AXI_ARVALID = 1'b1;
        @(negedge clk);
        bus.S_AXI_ARADDR = 5'h0C;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus.S_AXI_RVALID, bus.S_AXI_ARREADY} !== 2'b10 || bus.S_AXI_RDATA !== model[2]) begin
                n_bad++;
                $display("FAIL r_stall[%0d] got rv/arr=%b data=%h want 10/%h", i,
                         {bus.S_AXI_RVALID, bus.S_AXI_ARREADY}, bus.S_AXI_RDATA, model[2]);
            end
        end
        bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b1;
        @(negedge clk);
        bus.S_AXI_RREADY = 1'b0;
        n_cmp++;
        if ({bus.S_AXI_RVALID, bus.S_AXI_ARREADY} !== 2'b01) begin
            n_bad++;
            $display("FAIL r_release got rv/arr=%b want 01", {bus.S_AXI_RVALID, bus.S_AXI_ARREADY});
        end
        do_read(5'h0C, rd, r);
        n_cmp++;
        if (rd !== model[3]) begin n_bad++; $display("FAIL stall_no_second_write got %h want %h", rd, model[3]); end
    endtask

    task automatic test_same_edge();
        logic [31:0] old = model[1], nd = $urandom;
        @(negedge clk);
        bus.S_AXI_AWADDR = 5'h04; bus.S_AXI_WDATA = nd; bus.S_AXI_WSTRB = 4'hF;
        bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_BREADY = 1'b1;
        @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_ARADDR = 5'h04; bus.S_AXI_ARVALID = 1'b1;
        @(negedge clk);
        bus.S_AXI_ARVALID = 1'b0;
        model_write(5'h04, nd, 4'hF);
        n_cmp++;
        if ({bus.S_AXI_RVALID, bus.S_AXI_BVALID} !== 2'b11 || bus.S_AXI_RDATA !== old) begin
            n_bad++;
            $display("FAIL same_edge_read got rv/bv=%b data=%h want 11/%h", {bus.S_AXI_RVALID, bus.S_AXI_BVALID}, bus.S_AXI_RDATA, old);
        end
        n_cmp++;
        if (reg_out[63:32] !== nd) begin n_bad++; $display("FAIL same_edge_reg_out got %h want %h", reg_out[63:32], nd); end
        bus.S_AXI_RREADY = 1'b1;
        @(negedge clk);
        bus.S_AXI_RREADY = 1'b0; bus.S_AXI_BREADY = 1'b0;
    endtask

    task automatic test_random();
        logic [4:0]  a;
        logic [31:0] d, rd;
        logic [3:0]  st;
        logic [1:0]  r;
        int          lat;
        for (int k = 0; k < 60; k++) begin
            a = 5'($urandom);
            if ($urandom_range(7, 0) == 0) set_ro($urandom_range(3, 0), $urandom);
            if ($urandom_range(1, 0) == 1) begin
                d = $urandom;
                st = 4'($urandom);
                do_write(a, d, st, $urandom_range(3, 0), r, lat);
                model_write(a, d, st);
                n_cmp++;
                if (r !== exp_bresp(a)) begin n_bad++; $display("FAIL rnd_bresp addr=%h got %b want %b", a, r, exp_bresp(a)); end
            end else begin
                do_read(a, rd, r);
                n_cmp++;
                if (rd !== model[a[4:2]] || r !== 2'b00) begin
                    n_bad++;
                    $display("FAIL rnd_read addr=%h got %h/%b want %h/00", a, rd, r, model[a[4:2]]);
                end
            end
        end
        n_cmp++;
        if (reg_out !== {model[3], model[2], model[1], model[0]}) begin
            n_bad++;
            $display("FAIL rnd_reg_out got %h want %h", reg_out, {model[3], model[2], model[1], model[0]});
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic [1:0]  r;
        int          lat;
        @(negedge clk);
        bus.S_AXI_AWADDR = 5'h00; bus.S_AXI_AWVALID = 1'b1;
        @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID} !== 3'b000) begin
            n_bad++;
            $display("FAIL mid_reset_async got %b want 000", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) model[i] = RST;
        @(negedge clk);
        n_cmp++;
        if (reg_out !== {4{RST}} || {bus.S_AXI_BVALID, bus.S_AXI_AWREADY} !== 2'b01) begin
            n_bad++;
            $display("FAIL mid_reset_release got reg_out=%h bv/awr=%b want %h/01", reg_out,
                     {bus.S_AXI_BVALID, bus.S_AXI_AWREADY}, {4{RST}});
        end
        do_write(5'h08, 32'hCAFE0001, 4'hF, 0, r, lat);
        model_write(5'h08, 32'hCAFE0001, 4'hF);
        do_read(5'h00, rd, r);
        n_cmp++;
        if (rd !== RST || reg_out !== {model[3], model[2], model[1], model[0]}) begin
            n_bad++;
            $display("FAIL mid_reset_no_commit got reg0=%h want %h", rd, RST);
        end
    endtask

    initial begin
        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b0;
        ro_in = '0;
        for (int i = 0; i < 4; i++) model[i] = RST;
        for (int i = 0; i < 4; i++) set_ro(i, $urandom);
        test_reset();
        test_directed();
        test_w_first();
        test_strobe();
        test_ro();
        test_stall();
        test_same_edge();
        test_random();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ad7689_s_axi_regs.md
AD7689_S_AXI_REGS -- requirements
Module: ad7689_s_axi_regs

Interface
REQ-001 The module SHALL have parameter C_S_AXI_ADDR_WIDTH, default 5: byte address width, 8 word registers.
REQ-002 The module SHALL have parameter C_REG_RESET, default 32'h00000000: reset value of RW registers 0-3.
REQ-003 The module SHALL have port S_AXI_ACLK  in  1  sole clock, all logic on its rising edge.
REQ-004 The module SHALL have port S_AXI_ARESET  in  1  asynchronous, active-high reset.
REQ-005 The module SHALL have ports S_AXI_AWADDR in 5, S_AXI_AWPROT in 3, S_AXI_AWVALID in 1, S_AXI_AWREADY out 1: write address channel; PROT ignored.
REQ-006 The module SHALL have ports S_AXI_WDATA in 32, S_AXI_WSTRB in 4, S_AXI_WVALID in 1, S_AXI_WREADY out 1: write data channel.
REQ-007 The module SHALL have ports S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1: write response channel.
REQ-008 The module SHALL have ports S_AXI_ARADDR in 5, S_AXI_ARPROT in 3, S_AXI_ARVALID in 1, S_AXI_ARREADY out 1: read address channel; PROT ignored.
REQ-009 The module SHALL have ports S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1: read data channel.
REQ-010 The module SHALL have port reg_out  out  128  registers 0-3 concatenated, reg0 in bits [31:0].
REQ-011 The module SHALL have port ro_in  in  128  read-only words for registers 4-7, reg4 in bits [31:0].

Function
REQ-012 Word index SHALL be ADDR[4:2]; ADDR[1:0] ignored.
REQ-013 AWREADY SHALL equal NOT aw_held AND NOT BVALID; WREADY SHALL equal NOT w_held AND NOT BVALID; AW and W accepted independently in either order or the same edge, address/data/strobe latched.
REQ-014 On the first edge with aw_held AND w_held AND NOT BVALID: commit write, clear both held flags, set BVALID; minimum latency = 1 cycle after the later of the two handshakes.
REQ-015 Commit to registers 0-3 SHALL update only bytes whose WSTRB bit is 1; WSTRB=0000 completes with OKAY and changes nothing.
REQ-016 BVALID SHALL remain high, with BRESP stable, until the BVALID AND BREADY edge; it clears on that edge.
REQ-017 ARREADY SHALL equal NOT RVALID; on the ARVALID AND ARREADY edge, RDATA is loaded from the register (or ro_in word) and RVALID is set.
REQ-018 RVALID, RDATA and RRESP SHALL hold until the RVALID AND RREADY edge; RVALID clears on that edge; next AR is accepted one cycle later (max 1 read per 2 cycles).
REQ-019 A read handshake and a write commit to the same register on the same edge SHALL return the pre-commit value.
REQ-020 Read and write paths SHALL be independent; neither stalls the other.
REQ-021 reg_out SHALL reflect committed values from the cycle after commit.

Reset
REQ-022 While S_AXI_ARESET is high: AWREADY=0, WREADY=0, ARREADY=0, BVALID=0, RVALID=0, BRESP=00, RRESP=00, RDATA=0, held flags cleared, registers 0-3 = C_REG_RESET.
REQ-023 Reset asserted mid-transaction SHALL abort it; no partial commit; pending B/R responses are lost.
REQ-024 The ready outputs SHALL go high on the first edge after reset deasserts.

Configuration
REQ-025 With AD7689_SLVERR_EN defined: writes to registers 4-7 respond BRESP=10 (SLVERR) with no state change; reads always OKAY.
REQ-026 Without AD7689_SLVERR_EN: writes to registers 4-7 are ignored and respond BRESP=00; all responses OKAY.

Verification
REQ-027 Write 0x0101FFFF to 0x00, 0xABCD0001 to 0x04, 0xDEAD0011 to 0x08 and 0xBEEF0011 to 0x0C, then read each back -> same data, BRESP=RRESP=00, reg_out matches.
REQ-028 W sent 3 cycles before AW, data 0x12345678 to 0x04 -> BVALID 1 cycle after AW handshake; read 0x04 = 0x12345678.
REQ-029 Reg0=0xFFFFFFFF, then write 0x00000000 with WSTRB=0101 -> reg0=0xFF00FF00.
REQ-030 ro_in word 5 = 0x0000ABCD, read 0x14 -> 0x0000ABCD; write 0x14 -> BRESP=10 with macro, 00 without; read 0x14 unchanged.
REQ-031 Hold BREADY/RREADY low 5 cycles -> BVALID/RVALID and data stable, AWREADY/WREADY/ARREADY low, no second transaction accepted.
REQ-032 Assert reset while aw_held=1 and w_held=0 -> after release reg_out = C_REG_RESET, BVALID=0, AWREADY=1.
